// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants for the instruction fetch stage and the code that drives it:
//   - XLEN_DEF / RESET_PC_DEF : default address width and reset PC
//   - PC_INC                  : sequential PC step (one 32-bit word)
//   - INSTR_W                 : instruction word width
//   - opcode_e                : major opcodes already used by the decoder
//                               (OP_BRANCH, OP_JAL, ...), kept here so that
//                               instruction generators share one definition.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;
  localparam int          INSTR_W      = 32;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// Output register plus a one-entry skid register carrying {instr, pc} toward
// the decoder over a valid/ready handshake. The skid entry always drains
// ahead of any newly arriving word, so order is preserved.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   flush                 drop the output and skid contents (redirect)
//   in_valid/in_instr/in_pc   word arriving from instruction memory
//   out_valid/out_ready   handshake to the decoder
//   out_instr/out_pc      presented instruction and its address
//   skid_valid            skid register holds a word (used to throttle issue)
// -----------------------------------------------------------------------------
module fetch_skid_buffer #(
  parameter int DATA_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic              skid_valid
);

  logic [DATA_W-1:0] skid_instr;
  logic [XLEN-1:0]   skid_pc;
  logic              take;

  // Output slot can accept new content when empty or being consumed.
  assign take = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (take) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_instr  <= skid_instr;
        out_pc     <= skid_pc;
        skid_valid <= in_valid;
      end else begin
        out_valid  <= in_valid;
        skid_valid <= 1'b0;
        if (in_valid) begin
          out_instr <= in_instr;
          out_pc    <= in_pc;
        end
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
    end
  end

  // Skid payload carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (in_valid && !flush && (!take || skid_valid)) begin
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory (1-cycle latency) and hands {instr, pc} to the decoder
// through fetch_skid_buffer. A redirect flushes all fetched-but-unconsumed
// work and restarts fetch at the target on the following cycle.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN): a redirect to a target
// with nonzero low bits raises misalign_trap/misalign_pc and halts issue
// until an aligned redirect or reset. Without the macro the low two bits of
// redirect_pc are forced to zero.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   imem_req/imem_addr         read request and word-aligned address
//   imem_rdata                 read data, valid the cycle after imem_req
//   out_valid/out_ready        handshake to the decoder
//   out_instr/out_pc           presented instruction and its address
//   redirect_valid/redirect_pc control-flow redirect and its target
//   misalign_trap/misalign_pc  (FETCH_MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               misalign_trap,
  output logic [XLEN-1:0]    misalign_pc
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc_p1;
  logic [XLEN-1:0] redirect_target;
  logic            inflight;
  logic            kill_p1;
  logic            skid_valid;
  logic            issue;
  logic            resp_vld_p1;
  logic            halt;

  assign redirect_target = redirect_pc & ALIGN_MASK;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |redirect_pc[1:0];
  assign halt       = misalign_trap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_trap <= 1'b0;
      misalign_pc   <= '0;
    end else if (redirect_valid) begin
      misalign_trap <= misaligned;
      if (misaligned) misalign_pc <= redirect_pc;
    end
  end
`else
  assign halt = 1'b0;
`endif

  // Issue is withheld whenever the skid is occupied or the in-flight word
  // would have to land in it, so at most one word is ever beyond the skid.
  assign issue = !reset && !redirect_valid && !skid_valid && !halt &&
                 !(out_valid && !out_ready && inflight);

  assign imem_req  = issue;
  assign imem_addr = pc;

  // ---- stage p0 -> p1: request issue, PC update ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      kill_p1  <= 1'b0;
    end else begin
      inflight <= issue;
      kill_p1  <= redirect_valid;
      if (redirect_valid) begin
        pc <= redirect_target;
      end else if (issue) begin
        pc <= pc + XLEN'(PC_INC);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= pc;
  end

  // ---- stage p1: response pairing; killed responses and same-cycle
  // redirects never enter the buffer ----
  assign resp_vld_p1 = inflight && !kill_p1 && !redirect_valid;

  fetch_skid_buffer #(
    .DATA_W (INSTR_W),
    .XLEN   (XLEN)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .in_valid   (resp_vld_p1),
    .in_instr   (imem_rdata),
    .in_pc      (req_pc_p1),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .skid_valid (skid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The instruction memory model returns
// word[addr>>2] = addr>>2 one cycle after each request.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] misalign_pc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap  (misalign_trap),
    .misalign_pc    (misalign_pc)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr >> 2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] acc [3];
    int got;
    int idx;

    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc",    out_pc,         32'd0);
    check("rst_out_instr", out_instr,      32'd0);
    check("rst_imem_req",  32'(imem_req),  32'd0);

    // Reset release: first request this cycle, first out_valid two edges on.
    reset = 1'b0;
    #1;
    check("start_req",  32'(imem_req), 32'd1);
    check("start_addr", imem_addr,     32'd0);
    tick();
    check("lat1_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc",    out_pc,         32'(i * 4));
      check("stream_instr", out_instr,      32'(i));
    end

    // Back-pressure: hold 0x10 for three cycles.
    tick();
    check("stall_pre_pc", out_pc, 32'h10);
    out_ready = 1'b0;
    #1;
    check("stall_req0", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_valid", 32'(out_valid), 32'd1);
      check("stall_hold_pc",    out_pc,         32'h10);
      check("stall_no_req",     32'(imem_req),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (out_valid && out_ready) begin
        acc[got] = out_pc;
        check("acc_instr", out_instr, out_pc >> 2);
        got++;
      end
      tick();
    end
    check("acc_count", 32'(got), 32'd3);
    check("acc_pc0", acc[0], 32'h10);
    check("acc_pc1", acc[1], 32'h14);
    check("acc_pc2", acc[2], 32'h18);

    // Redirect with output held and skid full.
    check("pre_redir_pc", out_pc, 32'h1C);
    out_ready = 1'b0;
    tick();
    check("skid_full_no_req", 32'(imem_req), 32'd0);
    redirect(32'h100);
    out_ready = 1'b1;
    #1;
    check("redir_valid0", 32'(out_valid), 32'd0);
    check("redir_req",    32'(imem_req),  32'd1);
    check("redir_addr",   imem_addr,      32'h100);
    tick();
    check("redir_valid1", 32'(out_valid), 32'd0);
    tick();
    check("redir_out_valid", 32'(out_valid), 32'd1);
    check("redir_out_pc",    out_pc,         32'h100);
    check("redir_out_instr", out_instr,      32'h40);

    // Back-to-back redirects during steady streaming: last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    check("dbl_valid0", 32'(out_valid), 32'd0);
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    #1;
    idx = -1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) begin
        idx = c;
        break;
      end
      tick();
    end
    check("dbl_latency", 32'(idx), 32'd2);
    check("dbl_first_pc", out_pc, 32'h300);
    tick();
    check("dbl_next_pc", out_pc, 32'h304);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    repeat (2) tick();
    check("wrap_pc",    out_pc,    32'hFFFF_FFFC);
    check("wrap_instr", out_instr, 32'h3FFF_FFFF);
    tick();
    check("wrap_next_pc",    out_pc,    32'h0);
    check("wrap_next_instr", out_instr, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect(32'h402);
    #1;
    check("trap_set",    32'(misalign_trap), 32'd1);
    check("trap_pc",     misalign_pc,        32'h402);
    check("trap_no_req", 32'(imem_req),      32'd0);
    redirect(32'h400);
    #1;
    check("trap_clear",  32'(misalign_trap), 32'd0);
    repeat (2) tick();
    check("trap_resume_pc", out_pc, 32'h400);
`else
    redirect(32'h402);
    repeat (2) tick();
    check("align_pc",    out_pc,    32'h400);
    check("align_instr", out_instr, 32'h100);
`endif

    // Asynchronous reset between edges.
    tick();
    check("pre_areset_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", 32'(out_valid), 32'd0);
    check("areset_req",   32'(imem_req),  32'd0);
    check("areset_pc",    out_pc,         32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("restart_addr", imem_addr, 32'd0);
    tick();
    check("restart_lat1", 32'(out_valid), 32'd0);
    tick();
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_pc",    out_pc,         32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
